// File: rtl/dma_sched.sv
// Multi-channel descriptor scheduler feeding a single DMA master.
// Per-channel slots, round-robin grant, done pulse and sticky irq status.
module dma_sched #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int QTY_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0] req_src_i,
    input  logic [NUM_CH*ADDR_W-1:0] req_dst_i,
    input  logic [NUM_CH*QTY_W-1:0]  req_qty_i,
    output logic                     dma_en_o,
    output logic [ADDR_W-1:0]        dma_src_o,
    output logic [ADDR_W-1:0]        dma_dst_o,
    output logic [QTY_W-1:0]         dma_qty_o,
    input  logic                     dma_fin_i,
    output logic [NUM_CH-1:0]        done_o,
    output logic [NUM_CH-1:0]        irq_status_o,
    input  logic [NUM_CH-1:0]        irq_clr_i,
    output logic                     irq_o,
    output logic                     busy_o,
    output logic [2:0]               cur_ch_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [NUM_CH-1:0]   pend_r;
    logic [ADDR_W-1:0]   src_r [NUM_CH];
    logic [ADDR_W-1:0]   dst_r [NUM_CH];
    logic [QTY_W-1:0]    qty_r [NUM_CH];
    logic [CH_W-1:0]     last_grant_r;
    logic [CH_W-1:0]     cur_ch_r;
    logic                dma_en_r;
    logic [ADDR_W-1:0]   dma_src_r;
    logic [ADDR_W-1:0]   dma_dst_r;
    logic [QTY_W-1:0]    dma_qty_r;
    logic [NUM_CH-1:0]   done_r;
    logic [NUM_CH-1:0]   irq_status_r;
    logic                busy_r;

    logic [NUM_CH-1:0]   accept_s;
    logic                found_s;
    logic [CH_W-1:0]     grant_s;
    logic [CH_W-1:0]     idx_s;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v = {NUM_CH{1'b0}};
        v[ch] = 1'b1;
        return v;
    endfunction

    assign accept_s     = req_valid_i & ~pend_r;
    assign req_ready_o  = ~pend_r;
    assign dma_en_o     = dma_en_r;
    assign dma_src_o    = dma_src_r;
    assign dma_dst_o    = dma_dst_r;
    assign dma_qty_o    = dma_qty_r;
    assign done_o       = done_r;
    assign irq_status_o = irq_status_r;
    assign irq_o        = |irq_status_r;
    assign busy_o       = busy_r;
    assign cur_ch_o     = 3'(cur_ch_r);

    // Round-robin search starting just after the last served channel.
    always_comb begin
        found_s = 1'b0;
        grant_s = {CH_W{1'b0}};
        idx_s   = {CH_W{1'b0}};
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_s = CH_W'((int'(last_grant_r) + k) % NUM_CH);
            if (!found_s && pend_r[idx_s]) begin
                found_s = 1'b1;
                grant_s = idx_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Descriptor slot capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_r[i] <= {ADDR_W{1'b0}};
                dst_r[i] <= {ADDR_W{1'b0}};
                qty_r[i] <= {QTY_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept_s[i]) begin
                    src_r[i] <= req_src_i[i*ADDR_W +: ADDR_W];
                    dst_r[i] <= req_dst_i[i*ADDR_W +: ADDR_W];
                    qty_r[i] <= req_qty_i[i*QTY_W +: QTY_W];
                end
            end
        end
    end

    // Pending flags: set on accept, released at the end of the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept_s[i]) begin
                    pend_r[i] <= 1'b1;
                end else if (done_r[i]) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
            end
        end
    end

    // Sticky interrupt status; a completion beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (done_r[i]) begin
                    irq_status_r[i] <= 1'b1;
                end else if (irq_clr_i[i]) begin
                    irq_status_r[i] <= 1'b0;
                end else begin
                    irq_status_r[i] <= irq_status_r[i];
                end
            end
        end
    end

    // Scheduler FSM with registered DMA launch and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= CH_W'(NUM_CH - 1);
            cur_ch_r     <= {CH_W{1'b0}};
            dma_en_r     <= 1'b0;
            dma_src_r    <= {ADDR_W{1'b0}};
            dma_dst_r    <= {ADDR_W{1'b0}};
            dma_qty_r    <= {QTY_W{1'b0}};
            done_r       <= {NUM_CH{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            dma_en_r <= 1'b0;
            done_r   <= {NUM_CH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        cur_ch_r  <= grant_s;
                        dma_src_r <= src_r[grant_s];
                        dma_dst_r <= dst_r[grant_s];
                        dma_qty_r <= qty_r[grant_s];
                        busy_r    <= 1'b1;
                        // Zero-length transfers complete without touching the master.
                        if (qty_r[grant_s] == {QTY_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= onehot(grant_s);
                        end else begin
                            state_r  <= ST_ISSUE;
                            dma_en_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dma_fin_i) begin
                        state_r <= ST_DONE;
                        done_r  <= onehot(cur_ch_r);
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    last_grant_r <= cur_ch_r;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
